// File: rtl/dii_pkg.sv
// Shared flit format and route-state encoding for the DII ring router.
package dii_pkg;

   localparam int unsigned FLIT_W       = 16;
   localparam int unsigned DII_DEST_LSB = 0;

   typedef struct packed {
      logic [FLIT_W-1:0] data;
      logic              last;
      logic              valid;
   } dii_flit_t;

   typedef enum logic [1:0] {
      RT_IDLE,
      RT_LOCAL,
      RT_THROUGH
   } route_e;

endpackage

// File: rtl/dii_fifo.sv
// Show-ahead FIFO with full/empty flags; head word is valid whenever !empty_o.
module dii_fifo #(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             rd_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;

   // Extra pointer bit distinguishes full from empty.
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign rdata_o = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (wr_i && !full_o)  wr_q <= wr_q + 1'b1;
         if (rd_i && !empty_o) rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_i && !full_o) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/debug_ring_multiport_router.sv
// Ring router node serving PORTS local modules: buffered ingress with packet-atomic
// routing, and a round-robin egress arbiter merging local injections with through-traffic.
module debug_ring_multiport_router
   import dii_pkg::*;
#(
   parameter int unsigned PORTS        = 3,
   parameter int unsigned BASE_ID      = 0,
   parameter int unsigned ID_WIDTH     = 10,
   parameter int unsigned BUFFER_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [FLIT_W-1:0]         ring_in_data,
   input  logic                      ring_in_last,
   input  logic                      ring_in_valid,
   output logic                      ring_in_ready,
   output logic [FLIT_W-1:0]         ring_out_data,
   output logic                      ring_out_last,
   output logic                      ring_out_valid,
   input  logic                      ring_out_ready,
   input  logic [PORTS*FLIT_W-1:0]   local_in_data,
   input  logic [PORTS-1:0]          local_in_last,
   input  logic [PORTS-1:0]          local_in_valid,
   output logic [PORTS-1:0]          local_in_ready,
   output logic [PORTS*FLIT_W-1:0]   local_out_data,
   output logic [PORTS-1:0]          local_out_last,
   output logic [PORTS-1:0]          local_out_valid,
   input  logic [PORTS-1:0]          local_out_ready
);
   localparam int unsigned NSRC = PORTS + 1;
   localparam int unsigned SW   = $clog2(NSRC);
   localparam int unsigned LW   = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int unsigned FW   = FLIT_W + 1;

   logic [FW-1:0]       fifo_rdata;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_pop;
   dii_flit_t           head;
   logic [ID_WIDTH-1:0] dest_off;
   logic                head_local;
   route_e              state_q;
   logic [LW-1:0]       port_q;
   logic                route_local;
   logic [LW-1:0]       route_port;
   logic                local_pop;

   assign ring_in_ready = !fifo_full && !rst;

   dii_fifo #(
      .WIDTH (FW),
      .DEPTH (BUFFER_DEPTH)
   ) u_ingress_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (ring_in_valid && ring_in_ready),
      .wdata_i ({ring_in_data, ring_in_last}),
      .rd_i    (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      head.data  = fifo_rdata[FW-1:1];
      head.last  = fifo_rdata[0];
      head.valid = !fifo_empty;
   end

   // Unsigned wrap pushes IDs below BASE_ID out of the local range.
   assign dest_off   = head.data[DII_DEST_LSB +: ID_WIDTH] - ID_WIDTH'(BASE_ID);
   assign head_local = (32'(dest_off) < PORTS);

   // While idle the head is routed from its own header; otherwise the packet's stored route.
   always_comb begin
      route_local = 1'b0;
      route_port  = '0;
      if (state_q == RT_IDLE) begin
         route_local = head_local;
         route_port  = LW'(dest_off);
      end else begin
         route_local = (state_q == RT_LOCAL);
         route_port  = port_q;
      end
   end

   always_comb begin
      local_out_valid = '0;
      local_pop       = 1'b0;
      for (int k = 0; k < int'(PORTS); k++) begin
         local_out_data[k*FLIT_W +: FLIT_W] = head.data;
         local_out_last[k]                  = head.last;
         if (head.valid && route_local && (route_port == LW'(k))) begin
            local_out_valid[k] = 1'b1;
            local_pop          = local_out_ready[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RT_IDLE;
         port_q  <= '0;
      end else begin
         case (state_q)
            RT_IDLE: begin
               if (head.valid && !(fifo_pop && head.last)) begin
                  state_q <= head_local ? RT_LOCAL : RT_THROUGH;
                  port_q  <= LW'(dest_off);
               end
            end
            default: begin
               if (fifo_pop && head.last) state_q <= RT_IDLE;
            end
         endcase
      end
   end

   // Egress arbitration: sources 0..PORTS-1 are local_in, PORTS is through-traffic.
   logic [NSRC-1:0]   req;
   logic [FLIT_W-1:0] sel_data;
   logic              sel_last;
   logic              gnt_any;
   logic [SW-1:0]     gnt_idx;
   logic [SW-1:0]     cand;
   logic [SW-1:0]     last_q;
   logic [SW-1:0]     gnt_q;
   logic              lock_q;
   logic              out_accept;
   logic              xfer;
   dii_flit_t         out_q;
   dii_flit_t         out_d;

   always_comb begin
      req                = '0;
      req[PORTS]         = head.valid && !route_local;
      gnt_any            = 1'b0;
      gnt_idx            = last_q;
      cand               = '0;
      for (int k = 0; k < int'(PORTS); k++) req[k] = local_in_valid[k];
      if (lock_q) begin
         gnt_any = 1'b1;
         gnt_idx = gnt_q;
      end else begin
         for (int unsigned i = 1; i <= NSRC; i++) begin
            cand = SW'((32'(last_q) + i) % NSRC);
            if (!gnt_any && req[cand]) begin
               gnt_any = 1'b1;
               gnt_idx = cand;
            end
         end
      end
   end

   always_comb begin
      sel_data = head.data;
      sel_last = head.last;
      for (int k = 0; k < int'(PORTS); k++) begin
         if (gnt_idx == SW'(k)) begin
            sel_data = local_in_data[k*FLIT_W +: FLIT_W];
            sel_last = local_in_last[k];
         end
      end
   end

   assign out_accept = !out_q.valid || ring_out_ready;
   assign xfer       = gnt_any && req[gnt_idx] && out_accept;
   assign fifo_pop   = local_pop || (xfer && (gnt_idx == SW'(PORTS)));

   always_comb begin
      local_in_ready = '0;
      for (int k = 0; k < int'(PORTS); k++) begin
         local_in_ready[k] = !rst && gnt_any && out_accept && (gnt_idx == SW'(k));
      end
   end

   always_comb begin
      out_d = out_q;
      if (out_accept) begin
         out_d.valid = xfer;
         out_d.data  = sel_data;
         out_d.last  = sel_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= '0;
         lock_q <= 1'b0;
         gnt_q  <= SW'(PORTS);
         last_q <= SW'(PORTS);
      end else begin
         out_q <= out_d;
         if (xfer) begin
            last_q <= gnt_idx;
            gnt_q  <= gnt_idx;
            lock_q <= !sel_last;
         end
      end
   end

   assign ring_out_data  = out_q.data;
   assign ring_out_last  = out_q.last;
   assign ring_out_valid = out_q.valid;

endmodule

// File: tb/tb_debug_ring_multiport_router.sv
// Randomized bench for debug_ring_multiport_router with a per-source/per-port scoreboard.
module tb_debug_ring_multiport_router;
   localparam int unsigned PORTS = 3;
   localparam int unsigned BASE_ID = 1;
   localparam int unsigned ID_WIDTH = 10;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned NS = PORTS + 1;

   typedef struct {
      logic [15:0] data;
      logic        last;
      int          stamp;
   } ent_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [15:0]           ring_in_data = '0;
   logic                  ring_in_last = 1'b0;
   logic                  ring_in_valid = 1'b0;
   logic                  ring_in_ready;
   logic [15:0]           ring_out_data;
   logic                  ring_out_last;
   logic                  ring_out_valid;
   logic                  ring_out_ready = 1'b1;
   logic [PORTS*16-1:0]   local_in_data = '0;
   logic [PORTS-1:0]      local_in_last = '0;
   logic [PORTS-1:0]      local_in_valid = '0;
   logic [PORTS-1:0]      local_in_ready;
   logic [PORTS*16-1:0]   local_out_data;
   logic [PORTS-1:0]      local_out_last;
   logic [PORTS-1:0]      local_out_valid;
   logic [PORTS-1:0]      local_out_ready = '1;

   debug_ring_multiport_router #(
      .PORTS(PORTS), .BASE_ID(BASE_ID), .ID_WIDTH(ID_WIDTH), .BUFFER_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .ring_in_data(ring_in_data), .ring_in_last(ring_in_last),
      .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready),
      .ring_out_data(ring_out_data), .ring_out_last(ring_out_last),
      .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready),
      .local_in_data(local_in_data), .local_in_last(local_in_last),
      .local_in_valid(local_in_valid), .local_in_ready(local_in_ready),
      .local_out_data(local_out_data), .local_out_last(local_out_last),
      .local_out_valid(local_out_valid), .local_out_ready(local_out_ready)
   );

   always #5 clk = ~clk;

   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [16:0] txq [NS][$];
   bit          pend [NS];
   bit          fire_in [NS];
   bit          do_rst = 1'b1;
   bit          rnd_gap = 1'b0, rnd_ro = 1'b0, rnd_lo = 1'b0, lat_mode = 1'b0;
   logic        ro_force = 1'b1;
   logic [PORTS-1:0] lo_force = '1;
   ent_t        expo [NS][$];
   ent_t        expl [PORTS][$];
   int          pkt_order [$];
   bit          rin_in_pkt = 1'b0, ro_in_pkt = 1'b0;
   int          rin_port = 0, ro_src = 0, rin_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Drivers: hold each flit until it is accepted, optionally with random idle gaps.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < int'(NS); i++) begin
            if (fire_in[i]) begin
               void'(txq[i].pop_front());
               pend[i] = 1'b0;
            end
         end
         rst = do_rst;
         do_rst = 1'b0;
         if (rst) begin
            for (int i = 0; i < int'(NS); i++) begin
               txq[i].delete();
               pend[i] = 1'b0;
            end
         end
         for (int i = 0; i < int'(NS); i++) begin
            if (!pend[i] && txq[i].size() != 0 && (!rnd_gap || $urandom_range(3) != 0))
               pend[i] = 1'b1;
         end
         for (int k = 0; k < int'(NS); k++) begin
            logic [16:0] f;
            f = pend[k] ? txq[k][0] : 17'h0;
            if (k == int'(PORTS)) begin
               ring_in_valid = pend[k];
               ring_in_data  = f[16:1];
               ring_in_last  = f[0];
            end else begin
               local_in_valid[k]         = pend[k];
               local_in_data[k*16 +: 16] = f[16:1];
               local_in_last[k]          = f[0];
            end
         end
         ring_out_ready  = rnd_ro ? 1'($urandom_range(1)) : ro_force;
         local_out_ready = rnd_lo ? PORTS'($urandom) : lo_force;
      end
   end

   // Monitor and reference model: route by destination, check per-source order and atomicity.
   always @(negedge clk) begin
      for (int i = 0; i < int'(NS); i++) fire_in[i] = 1'b0;
      if (rst) begin
         for (int i = 0; i < int'(NS); i++) expo[i].delete();
         for (int k = 0; k < int'(PORTS); k++) expl[k].delete();
         rin_in_pkt = 1'b0;
         ro_in_pkt  = 1'b0;
      end else begin
         for (int k = 0; k < int'(PORTS); k++) begin
            if (local_in_valid[k] && local_in_ready[k]) begin
               fire_in[k] = 1'b1;
               expo[k].push_back('{local_in_data[k*16 +: 16], local_in_last[k], cyc});
            end
         end
         if (ring_in_valid && ring_in_ready) begin
            fire_in[PORTS] = 1'b1;
            rin_acc++;
            if (!rin_in_pkt) begin
               int off;
               off = int'(ring_in_data[ID_WIDTH-1:0]) - int'(BASE_ID);
               rin_port = (off >= 0 && off < int'(PORTS)) ? off : int'(PORTS);
            end
            rin_in_pkt = !ring_in_last;
            if (rin_port < int'(PORTS))
               expl[rin_port].push_back('{ring_in_data, ring_in_last, cyc});
            else
               expo[PORTS].push_back('{ring_in_data, ring_in_last, cyc});
         end
         if ($countones(local_out_valid) > 1)
            check("local_out_onehot", $countones(local_out_valid), 1);
         for (int k = 0; k < int'(PORTS); k++) begin
            if (local_out_valid[k] && local_out_ready[k]) begin
               if (expl[k].size() == 0) begin
                  check("local_out_unexpected", k, 99);
               end else begin
                  ent_t e;
                  e = expl[k].pop_front();
                  check("local_out_flit", {local_out_data[k*16 +: 16], local_out_last[k]},
                        {e.data, e.last});
                  if (lat_mode) check("local_out_latency", cyc - e.stamp, 1);
               end
            end
         end
         if (ring_out_valid && ring_out_ready) begin
            int src;
            src = int'(ring_out_data[15:13]);
            if (!ro_in_pkt) begin
               ro_src = src;
               pkt_order.push_back(src);
            end
            check("ring_out_atomic_src", src, ro_src);
            if (src >= int'(NS) || expo[src].size() == 0) begin
               check("ring_out_unexpected", src, 99);
            end else begin
               ent_t e;
               e = expo[src].pop_front();
               check("ring_out_flit", {ring_out_data, ring_out_last}, {e.data, e.last});
               if (lat_mode) check("ring_out_latency", cyc - e.stamp, (src == int'(PORTS)) ? 2 : 1);
            end
            ro_in_pkt = !ring_out_last;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic queue_pkt(input int src, input int nflits, input int dest);
      for (int i = 0; i < nflits; i++) begin
         logic [15:0] d;
         d = 16'($urandom);
         d[15:13] = 3'(src);
         if (i == 0) d[9:0] = 10'(dest);
         txq[src].push_back({d, 1'(i == nflits - 1)});
      end
   endtask

   function automatic bit all_empty();
      bit e;
      e = 1'b1;
      for (int i = 0; i < int'(NS); i++) if (txq[i].size() != 0 || expo[i].size() != 0) e = 1'b0;
      for (int k = 0; k < int'(PORTS); k++) if (expl[k].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic wait_drain(input string tag, input int maxc);
      int n;
      n = 0;
      while (!all_empty() && n < maxc) begin
         tick(1);
         n++;
      end
      tick(2);
      check(tag, all_empty(), 1);
   endtask

   initial begin
      tick(1);
      check("reset_ring_in_ready", ring_in_ready, 0);
      check("reset_local_in_ready", local_in_ready, 0);
      check("reset_ring_out_valid", ring_out_valid, 0);
      check("reset_local_out_valid", local_out_valid, 0);
      tick(1);
      check("post_reset_ring_in_ready", ring_in_ready, 1);

      lat_mode = 1'b1;
      queue_pkt(PORTS, 3, 2);
      wait_drain("drain_local_dest2", 50);
      queue_pkt(PORTS, 2, 10'h3FF);
      wait_drain("drain_through_3ff", 50);
      queue_pkt(PORTS, 1, 0);
      wait_drain("drain_through_below_base", 50);
      queue_pkt(0, 2, 5);
      wait_drain("drain_local_in0", 50);
      queue_pkt(2, 3, 1);
      wait_drain("drain_local_in2", 50);
      lat_mode = 1'b0;

      pkt_order.delete();
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < int'(NS); s++)
            queue_pkt(s, 2, (s == int'(PORTS)) ? 10'h200 : int'($urandom_range(1023)));
      wait_drain("drain_round_robin", 100);
      check("rr_packet_count", pkt_order.size(), 2 * NS);
      for (int i = 0; i < pkt_order.size(); i++)
         check("rr_order", pkt_order[i], i % int'(NS));

      rin_acc = 0;
      lo_force = 3'b110;
      queue_pkt(PORTS, 6, BASE_ID);
      tick(12);
      check("hol_accepted", rin_acc, DEPTH);
      check("hol_ring_in_ready", ring_in_ready, 0);
      check("hol_local_out_valid", local_out_valid, 3'b001);
      lo_force = '1;
      wait_drain("drain_hol_release", 60);

      rnd_gap = 1'b1;
      rnd_ro = 1'b1;
      rnd_lo = 1'b1;
      for (int p = 0; p < 80; p++) begin
         int src;
         int dest;
         src = int'($urandom_range(PORTS));
         dest = ($urandom_range(1) != 0) ? int'($urandom_range(5)) : int'($urandom_range(1023));
         queue_pkt(src, int'($urandom_range(4, 1)), dest);
      end
      wait_drain("drain_random", 4000);
      rnd_gap = 1'b0;
      rnd_ro = 1'b0;
      rnd_lo = 1'b0;

      lo_force = '0;
      ro_force = 1'b0;
      queue_pkt(PORTS, 6, 2);
      queue_pkt(0, 4, 5);
      tick(4);
      do_rst = 1'b1;
      tick(1);
      check("midreset_ring_in_ready", ring_in_ready, 0);
      check("midreset_local_in_ready", local_in_ready, 0);
      tick(1);
      check("after_reset_ring_out_valid", ring_out_valid, 0);
      check("after_reset_local_out_valid", local_out_valid, 0);
      check("after_reset_local_in_ready", local_in_ready, 0);
      lo_force = '1;
      ro_force = 1'b1;
      lat_mode = 1'b1;
      queue_pkt(PORTS, 2, 3);
      wait_drain("drain_after_reset_local", 50);
      queue_pkt(1, 2, 7);
      wait_drain("drain_after_reset_inject", 50);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
